// File: rtl/dma_pcie_c2h_byp_out_sched.sv
// Credit-gated round-robin scheduler for the C2H descriptor bypass-out port.
// One descriptor per cycle, 1-cycle registered latency; credits are the only flow control.
`ifndef QID_WIDTH
`define QID_WIDTH 11
`endif

module dma_pcie_c2h_byp_out_sched #(
  parameter int QID_W    = `QID_WIDTH,
  parameter int CRDT_MAX = 16,
  parameter int CRDT_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cfg_chn_en,
  input  logic [3:0]            req_vld,
  output logic [3:0]            req_rdy,
  input  logic [4*64-1:0]       req_dsc,
  input  logic [4*QID_W-1:0]    req_qid,
  input  logic [4*16-1:0]       req_cidx,
  input  logic [3:0]            req_wbi,
  input  logic [3:0]            req_wbi_chk,
  input  logic [3:0]            req_last,
  input  logic [3:0]            req_lsiz,
  output logic [63:0]           byp_out_dsc,
  output logic [QID_W-1:0]      byp_out_qid,
  output logic                  byp_out_wbi,
  output logic                  byp_out_wbi_chk,
  output logic [15:0]           byp_out_cidx,
  output logic                  byp_out_last,
  output logic                  byp_out_lsiz,
  output logic [1:0]            byp_out_chn,
  output logic                  byp_out_vld,
  input  logic [1:0]            byp_out_crdt_chn,
  input  logic                  byp_out_crdt,
  output logic [4*CRDT_W-1:0]   crdt_cnt,
  output logic                  err_crdt_ovf
);

  logic [3:0][CRDT_W-1:0] crdt_q, crdt_d;
  logic [1:0]             rr_q, rr_d;
  logic                   err_q, err_d;
  logic                   vld_q, vld_d;
  logic [63:0]            dsc_q, dsc_d;
  logic [QID_W-1:0]       qid_q, qid_d;
  logic [15:0]            cidx_q, cidx_d;
  logic                   wbi_q, wbi_d;
  logic                   wbi_chk_q, wbi_chk_d;
  logic                   last_q, last_d;
  logic                   lsiz_q, lsiz_d;
  logic [1:0]             chn_q, chn_d;

  logic [3:0] elig;
  logic [1:0] idx;
  logic [1:0] win;
  logic       win_vld;

  // Eligibility uses registered credit counts only, so a returned credit counts next cycle.
  always_comb begin
    elig    = '0;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    req_rdy = '0;
    for (int c = 0; c < 4; c++) begin
      elig[c] = req_vld[c] & cfg_chn_en[c] & (crdt_q[c] != '0);
    end
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
    if (win_vld) req_rdy[win] = 1'b1;
  end

  always_comb begin
    crdt_d = crdt_q;
    err_d  = err_q;
    rr_d   = rr_q;
    for (int c = 0; c < 4; c++) begin
      logic inc, dec;
      inc = byp_out_crdt & (byp_out_crdt_chn == 2'(c));
      dec = win_vld & (win == 2'(c));
      if (inc && !dec) begin
        if (crdt_q[c] == CRDT_W'(CRDT_MAX)) err_d = 1'b1;
        else                               crdt_d[c] = crdt_q[c] + CRDT_W'(1);
      end else if (dec && !inc) begin
        crdt_d[c] = crdt_q[c] - CRDT_W'(1);
      end
    end
    if (win_vld) rr_d = win + 2'd1;
  end

  // Output data registers hold their last value when nothing is issued.
  always_comb begin
    vld_d     = win_vld;
    dsc_d     = dsc_q;
    qid_d     = qid_q;
    cidx_d    = cidx_q;
    wbi_d     = wbi_q;
    wbi_chk_d = wbi_chk_q;
    last_d    = last_q;
    lsiz_d    = lsiz_q;
    chn_d     = chn_q;
    if (win_vld) begin
      dsc_d     = req_dsc[win*64 +: 64];
      qid_d     = req_qid[win*QID_W +: QID_W];
      cidx_d    = req_cidx[win*16 +: 16];
      wbi_d     = req_wbi[win];
      wbi_chk_d = req_wbi_chk[win];
      last_d    = req_last[win];
      lsiz_d    = req_lsiz[win];
      chn_d     = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crdt_q    <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      dsc_q     <= '0;
      qid_q     <= '0;
      cidx_q    <= '0;
      wbi_q     <= 1'b0;
      wbi_chk_q <= 1'b0;
      last_q    <= 1'b0;
      lsiz_q    <= 1'b0;
      chn_q     <= '0;
    end else begin
      crdt_q    <= crdt_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      dsc_q     <= dsc_d;
      qid_q     <= qid_d;
      cidx_q    <= cidx_d;
      wbi_q     <= wbi_d;
      wbi_chk_q <= wbi_chk_d;
      last_q    <= last_d;
      lsiz_q    <= lsiz_d;
      chn_q     <= chn_d;
    end
  end

  assign byp_out_vld     = vld_q;
  assign byp_out_dsc     = dsc_q;
  assign byp_out_qid     = qid_q;
  assign byp_out_cidx    = cidx_q;
  assign byp_out_wbi     = wbi_q;
  assign byp_out_wbi_chk = wbi_chk_q;
  assign byp_out_last    = last_q;
  assign byp_out_lsiz    = lsiz_q;
  assign byp_out_chn     = chn_q;
  assign crdt_cnt        = crdt_q;
  assign err_crdt_ovf    = err_q;

endmodule

// File: tb/tb_dma_pcie_c2h_byp_out_sched.sv
// Bench for dma_pcie_c2h_byp_out_sched: directed scenarios plus random traffic
// checked cycle by cycle against a credit/round-robin reference model.
module tb_dma_pcie_c2h_byp_out_sched;
  localparam int QW = 11;
  localparam int CW = 5;
  localparam int CMAX = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        cfg_chn_en = '0;
  logic [3:0]        req_vld = '0;
  logic [3:0]        req_rdy;
  logic [4*64-1:0]   req_dsc = '0;
  logic [4*QW-1:0]   req_qid = '0;
  logic [4*16-1:0]   req_cidx = '0;
  logic [3:0]        req_wbi = '0, req_wbi_chk = '0, req_last = '0, req_lsiz = '0;
  logic [63:0]       byp_out_dsc;
  logic [QW-1:0]     byp_out_qid;
  logic              byp_out_wbi, byp_out_wbi_chk, byp_out_last, byp_out_lsiz, byp_out_vld;
  logic [15:0]       byp_out_cidx;
  logic [1:0]        byp_out_chn;
  logic [1:0]        byp_out_crdt_chn = '0;
  logic              byp_out_crdt = 1'b0;
  logic [4*CW-1:0]   crdt_cnt;
  logic              err_crdt_ovf;

  dma_pcie_c2h_byp_out_sched #(.QID_W(QW), .CRDT_MAX(CMAX), .CRDT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_chn_en(cfg_chn_en), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_dsc(req_dsc), .req_qid(req_qid), .req_cidx(req_cidx), .req_wbi(req_wbi),
    .req_wbi_chk(req_wbi_chk), .req_last(req_last), .req_lsiz(req_lsiz),
    .byp_out_dsc(byp_out_dsc), .byp_out_qid(byp_out_qid), .byp_out_wbi(byp_out_wbi),
    .byp_out_wbi_chk(byp_out_wbi_chk), .byp_out_cidx(byp_out_cidx), .byp_out_last(byp_out_last),
    .byp_out_lsiz(byp_out_lsiz), .byp_out_chn(byp_out_chn), .byp_out_vld(byp_out_vld),
    .byp_out_crdt_chn(byp_out_crdt_chn), .byp_out_crdt(byp_out_crdt),
    .crdt_cnt(crdt_cnt), .err_crdt_ovf(err_crdt_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: credits, next-priority channel, sticky error, last issued descriptor.
  int          m_cr[4];
  int          m_rr;
  bit          m_err;
  bit          e_vld;
  logic [63:0] e_dsc;
  logic [QW-1:0] e_qid;
  logic [15:0] e_cidx;
  bit          e_wbi, e_wbi_chk, e_last, e_lsiz;
  int          e_chn;
  logic [3:0]  last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) m_cr[c] = 0;
    m_rr = 0; m_err = 0; e_vld = 0; e_dsc = '0; e_qid = '0; e_cidx = '0;
    e_wbi = 0; e_wbi_chk = 0; e_last = 0; e_lsiz = 0; e_chn = 0; last_acc = '0;
  endtask

  task automatic check_state();
    chk("byp_vld", 64'(byp_out_vld), 64'(e_vld));
    chk("byp_dsc", byp_out_dsc, e_dsc);
    chk("byp_qid", 64'(byp_out_qid), 64'(e_qid));
    chk("byp_cidx", 64'(byp_out_cidx), 64'(e_cidx));
    chk("byp_flags", 64'({byp_out_wbi, byp_out_wbi_chk, byp_out_last, byp_out_lsiz}),
        64'({e_wbi, e_wbi_chk, e_last, e_lsiz}));
    chk("byp_chn", 64'(byp_out_chn), 64'(e_chn));
    for (int c = 0; c < 4; c++) chk("crdt_cnt", 64'(crdt_cnt[c*CW +: CW]), 64'(m_cr[c]));
    chk("err_ovf", 64'(err_crdt_ovf), 64'(m_err));
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    int g;
    logic [3:0] exp_rdy;
    #1;
    g = -1;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (m_rr + i) % 4;
      if (g < 0 && req_vld[c] && cfg_chn_en[c] && m_cr[c] > 0) g = c;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    last_acc = exp_rdy;
    for (int c = 0; c < 4; c++) begin
      bit inc, dec;
      inc = byp_out_crdt && (byp_out_crdt_chn == c);
      dec = (g == c);
      if (inc && !dec) begin
        if (m_cr[c] == CMAX) m_err = 1; else m_cr[c] = m_cr[c] + 1;
      end else if (dec && !inc) begin
        m_cr[c] = m_cr[c] - 1;
      end
    end
    e_vld = (g >= 0);
    if (g >= 0) begin
      m_rr = (g + 1) % 4;
      e_chn = g;
      e_dsc = req_dsc[g*64 +: 64];
      e_qid = req_qid[g*QW +: QW];
      e_cidx = req_cidx[g*16 +: 16];
      e_wbi = req_wbi[g]; e_wbi_chk = req_wbi_chk[g];
      e_last = req_last[g]; e_lsiz = req_lsiz[g];
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld = '0; byp_out_crdt = 1'b0; byp_out_crdt_chn = '0;
    model_reset();
    @(posedge clk); #1;
    check_state();
    chk("rdy_rst", 64'(req_rdy), 64'd0);
    rst = 1'b0;
  endtask

  task automatic credit(input int chn, input int n);
    req_vld = '0;
    for (int i = 0; i < n; i++) begin
      byp_out_crdt = 1'b1; byp_out_crdt_chn = 2'(chn);
      cycle();
    end
    byp_out_crdt = 1'b0;
  endtask

  task automatic rand_fields(input int c);
    req_dsc[c*64 +: 64] = {$urandom, $urandom};
    req_qid[c*QW +: QW] = QW'($urandom);
    req_cidx[c*16 +: 16] = 16'($urandom);
    req_wbi[c] = 1'($urandom); req_wbi_chk[c] = 1'($urandom);
    req_last[c] = 1'($urandom); req_lsiz[c] = 1'($urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // No credits: nothing may be granted.
    cfg_chn_en = 4'hF;
    for (int c = 0; c < 4; c++) rand_fields(c);
    req_vld = 4'hF;
    for (int i = 0; i < 20; i++) cycle();

    // Three credits on chn 2, back-to-back issue, then starve.
    do_reset();
    credit(2, 3);
    req_qid[2*QW +: QW] = QW'(11'h15);
    req_vld = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("c2_vld", 64'(byp_out_vld), 64'd1);
      chk("c2_qid", 64'(byp_out_qid), 64'h15);
      chk("c2_cnt", 64'(crdt_cnt[2*CW +: CW]), 64'(2 - i));
    end
    cycle();
    chk("c2_rdy0", 64'(req_rdy[2]), 64'd0);

    // Two credits everywhere: strict rotation 0,1,2,3,0,1,2,3.
    do_reset();
    for (int c = 0; c < 4; c++) credit(c, 2);
    req_vld = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_order", 64'(byp_out_chn), 64'(i % 4));
    end
    for (int i = 0; i < 3; i++) cycle();

    // Credit return and accept on the same channel in the same cycle.
    do_reset();
    credit(1, 1);
    req_vld = 4'b0010;
    byp_out_crdt = 1'b1; byp_out_crdt_chn = 2'd1;
    cycle();
    chk("same_cyc_cnt", 64'(crdt_cnt[1*CW +: CW]), 64'd1);
    byp_out_crdt = 1'b0;
    cycle();
    chk("regrant_chn1", 64'({byp_out_vld, byp_out_chn}), 64'({1'b1, 2'd1}));
    req_vld = '0;
    cycle();

    // Overflow: 17 returns to chn 0.
    do_reset();
    credit(0, 16);
    chk("ovf_pre", 64'(err_crdt_ovf), 64'd0);
    credit(0, 1);
    chk("ovf_cnt", 64'(crdt_cnt[CW-1:0]), 64'd16);
    chk("ovf_set", 64'(err_crdt_ovf), 64'd1);
    for (int i = 0; i < 5; i++) cycle();
    chk("ovf_sticky", 64'(err_crdt_ovf), 64'd1);

    // Disabled chn 1, then reset mid-burst.
    do_reset();
    cfg_chn_en = 4'b1101;
    for (int c = 0; c < 4; c++) credit(c, 3);
    req_vld = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("dis_chn1", 64'(req_rdy[1]), 64'd0);
    end
    rst = 1'b1;
    #1;
    chk("rst_vld", 64'(byp_out_vld), 64'd0);
    chk("rst_cnt", 64'(crdt_cnt), 64'd0);
    @(posedge clk); #1;
    do_reset();

    // Random traffic; unaccepted valid requests keep their fields stable.
    cfg_chn_en = 4'hF;
    req_vld = '0;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) cfg_chn_en = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        if (!(req_vld[c] && !last_acc[c])) begin
          req_vld[c] = ($urandom_range(0, 2) != 0);
          rand_fields(c);
        end
      end
      byp_out_crdt = ($urandom_range(0, 2) != 0);
      byp_out_crdt_chn = 2'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
